spi_mem_ctrl: RTL



---
 rtl/cpu_spi_pkg.sv | 17 +
 rtl/spi_clk_div.sv | 43 ++++
 rtl/spi_mem_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cpu_spi_pkg.sv
// Shared constants and state encoding for the CPU-side SPI RAM master.
package cpu_spi_pkg;

    localparam logic [7:0]  SPI_CMD_READ  = 8'h03;
    localparam logic [7:0]  SPI_CMD_WRITE = 8'h02;
    localparam int unsigned CMD_BITS      = 8;
    localparam int unsigned FRAME_BITS    = 48;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SELECT   = 3'd1,
        SHIFT    = 3'd2,
        DESELECT = 3'd3,
        DONE     = 3'd4
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// SPI clock generator: while run is high, spi_clk toggles every CLK_DIV
// clk cycles starting from a low phase. Strobes flag the cycle whose
// closing edge raises or lowers spi_clk.
module spi_clk_div #(
    parameter int unsigned CLK_DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic rise_strobe,
    output logic fall_strobe,
    output logic spi_clk
);

    localparam int unsigned           CNT_W    = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt;
    logic             level;
    logic             phase_end;

    assign phase_end   = run && (cnt == CNT_LAST);
    assign rise_strobe = phase_end && !level;
    assign fall_strobe = phase_end && level;
    assign spi_clk     = level;

    // Phase counter and clock level; both park at zero whenever run drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (!run) begin
            cnt   <= '0;
            level <= 1'b0;
        end else if (phase_end) begin
            cnt   <= '0;
            level <= ~level;
        end else begin
            cnt   <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/spi_mem_ctrl.sv
// CPU-side SPI master: one 16-bit load/store per SPI RAM frame
// {cmd, addr, data}, MSB first, SPI mode 0.
module spi_mem_ctrl
    import cpu_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = 1,
    parameter int unsigned ADDR_W  = 24,
    parameter int unsigned DATA_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              busy,
    output logic              spi_select,
    output logic              spi_clk,
    output logic              spi_mosi,
    input  logic              spi_miso
);

    localparam int unsigned        FRAME_W   = CMD_BITS + ADDR_W + DATA_W;
    localparam int unsigned        BIT_W     = $clog2(FRAME_W);
    localparam logic [BIT_W-1:0]   BIT_FIRST = BIT_W'(FRAME_W - 1);
    localparam logic [BIT_W-1:0]   DATA_BITS = BIT_W'(DATA_W);

    spi_state_e         state;
    logic [FRAME_W-1:0] shreg;
    logic [FRAME_W-1:0] frame;
    logic [BIT_W-1:0]   bit_cnt;
    logic               is_read;
    logic [DATA_W-1:0]  rx;
    logic               run;
    logic               rise_strobe;
    logic               fall_strobe;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign run       = (state == SELECT) || (state == SHIFT);

    // Outgoing frame; read frames carry zeros in the data field.
    always_comb begin
        frame = {(req_write ? SPI_CMD_WRITE : SPI_CMD_READ),
                 req_addr,
                 (req_write ? req_wdata : {DATA_W{1'b0}})};
    end

    spi_clk_div #(
        .CLK_DIV (CLK_DIV)
    ) u_clk_div (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .rise_strobe (rise_strobe),
        .fall_strobe (fall_strobe),
        .spi_clk     (spi_clk)
    );

    // Transfer sequencer: accept, shift 48 bits, deselect, report completion.
    // SELECT doubles as the first low-phase cycle of bit 47, so strobes are
    // serviced there as well as in SHIFT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            is_read    <= 1'b0;
            rx         <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            spi_select <= 1'b0;
            spi_mosi   <= 1'b0;
        end else begin
            resp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        shreg      <= frame;
                        bit_cnt    <= BIT_FIRST;
                        is_read    <= !req_write;
                        spi_select <= 1'b1;
                        spi_mosi   <= frame[FRAME_W-1];
                        state      <= SELECT;
                    end
                end
                SELECT, SHIFT: begin
                    state <= SHIFT;
                    if (rise_strobe && is_read && (bit_cnt < DATA_BITS)) begin
                        rx <= {rx[DATA_W-2:0], spi_miso};
                    end
                    if (fall_strobe) begin
                        if (bit_cnt == '0) begin
                            spi_select <= 1'b0;
                            spi_mosi   <= 1'b0;
                            state      <= DESELECT;
                        end else begin
                            bit_cnt  <= bit_cnt - 1'b1;
                            shreg    <= {shreg[FRAME_W-2:0], 1'b0};
                            spi_mosi <= shreg[FRAME_W-2];
                        end
                    end
                end
                DESELECT: begin
                    resp_valid <= 1'b1;
                    if (is_read) begin
                        resp_rdata <= rx;
                    end
                    state <= DONE;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
